sasa_match_enum: RTL and testbench

- Parametrised, sequential successor to the single-shot leading-match selector of the SASA CAM datapath.
- Accepts one CAM OR-match vector per transaction and enumerates every set bit in priority order, one per output beat.
- Each beat carries one-hot vector, binary index, ordinal and last flag.
- Adds per-transaction direction select, a per-vector emit limit, abort and valid/ready flow control on both sides.

---
 rtl/sasa_pkg.sv | 18 +
 rtl/sasa_prio_sel.sv | 36 +++
 rtl/sasa_match_enum.sv | 190 +++++++++++++++++++
 tb/tb_sasa_match_enum.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/sasa_pkg.sv
// Shared SASA CAM datapath definitions.
// Contents: CAM length constant, direction encodings and the match-enumerator
// FSM state type.
package sasa_pkg;

    localparam int unsigned SASA_CAM_LEN = 256;
    localparam int unsigned SASA_SEG_LEN = 16;

    localparam logic DIR_HI_FIRST = 1'b0;
    localparam logic DIR_LO_FIRST = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FIND = 2'd1,
        EMIT = 2'd2
    } state_t;

endpackage

// File: rtl/sasa_prio_sel.sv
// Combinational priority selector with a run-time direction.
// Ports:
//   req    - request vector
//   dir    - DIR_HI_FIRST picks the highest set bit, DIR_LO_FIRST the lowest
//   found  - any request set
//   onehot - winning request, one-hot (zero when nothing is set)
//   index  - binary index of the winner (zero when nothing is set)
module sasa_prio_sel
    import sasa_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    localparam int unsigned IW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic [WIDTH-1:0] req,
    input  logic             dir,
    output logic             found,
    output logic [WIDTH-1:0] onehot,
    output logic [IW-1:0]    index
);

    // Later hits overwrite earlier ones, so the scan order decides the winner.
    always_comb begin
        found  = |req;
        index  = '0;
        onehot = '0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (dir == DIR_HI_FIRST) begin
                if (req[i]) index = IW'(i);
            end else begin
                if (req[WIDTH-1-i]) index = IW'(WIDTH-1-i);
            end
        end
        if (found) onehot[index] = 1'b1;
    end

endmodule

// File: rtl/sasa_match_enum.sv
// Sequential match enumerator: accepts one CAM OR-match vector and emits every
// set bit in priority order, one beat per handshake.
// Ports:
//   clk, rst_n              - clock, synchronous active-low reset
//   in_valid/in_ready       - vector handshake (in_ready only in IDLE)
//   in_vector, in_dir,
//   in_limit                - vector, direction and beat limit (0 = unlimited)
//   abort                   - drop the current transaction
//   out_valid/out_ready     - beat handshake
//   out_onehot, out_index,
//   out_ord, out_last,
//   out_none                - beat payload
//   busy                    - not IDLE
module sasa_match_enum
    import sasa_pkg::*;
#(
    parameter int unsigned VEC_LEN = SASA_CAM_LEN,
    parameter int unsigned SEG_LEN = SASA_SEG_LEN,
    localparam int unsigned IDX_W = $clog2(VEC_LEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [VEC_LEN-1:0] in_vector,
    input  logic               in_dir,
    input  logic [IDX_W:0]     in_limit,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [VEC_LEN-1:0] out_onehot,
    output logic [IDX_W-1:0]   out_index,
    output logic [IDX_W:0]     out_ord,
    output logic               out_last,
    output logic               out_none,
    output logic               busy
);

    localparam int unsigned NSEG  = VEC_LEN / SEG_LEN;
    localparam int unsigned SEG_W = $clog2(NSEG);
    localparam int unsigned BIT_W = $clog2(SEG_LEN);
    localparam int unsigned CNT_W = IDX_W + 1;

    state_t state;
    state_t state_nxt;

    logic [VEC_LEN-1:0] residual;
    logic               dir_q;
    logic [CNT_W-1:0]   limit_q;
    logic [CNT_W-1:0]   ord;

    logic               accept_c;
    logic               beat_c;

    logic [NSEG-1:0]    seg_nz;
    logic               seg_found;
    logic [NSEG-1:0]    seg_oh;
    logic [SEG_W-1:0]   seg_idx;
    logic [IDX_W-1:0]   seg_base;
    logic [SEG_LEN-1:0] seg_word;
    logic               bit_found;
    logic [SEG_LEN-1:0] bit_oh;
    logic [BIT_W-1:0]   bit_idx;

    logic               found_c;
    logic [VEC_LEN-1:0] onehot_c;
    logic [IDX_W-1:0]   index_c;
    logic               last_c;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and handshake strobes; abort overrides every transition.
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        beat_c    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept_c  = 1'b1;
                    state_nxt = FIND;
                end
            end
            FIND: state_nxt = EMIT;
            EMIT: begin
                if (out_ready) begin
                    beat_c    = 1'b1;
                    state_nxt = out_last ? IDLE : FIND;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) begin
            state_nxt = IDLE;
            accept_c  = 1'b0;
            beat_c    = 1'b0;
        end
    end

    // Per-segment nonzero flags for the coarse search.
    always_comb begin
        seg_nz = '0;
        for (int unsigned s = 0; s < NSEG; s++) begin
            seg_nz[s] = |residual[s*SEG_LEN +: SEG_LEN];
        end
    end

    sasa_prio_sel #(.WIDTH(NSEG)) u_seg_sel (
        .req    (seg_nz),
        .dir    (dir_q),
        .found  (seg_found),
        .onehot (seg_oh),
        .index  (seg_idx)
    );

    assign seg_base = {seg_idx, {BIT_W{1'b0}}};
    assign seg_word = residual[seg_base +: SEG_LEN];

    sasa_prio_sel #(.WIDTH(SEG_LEN)) u_bit_sel (
        .req    (seg_word),
        .dir    (dir_q),
        .found  (bit_found),
        .onehot (bit_oh),
        .index  (bit_idx)
    );

    // Full-width one-hot is the outer product of the two one-hot selections.
    always_comb begin
        onehot_c = '0;
        for (int unsigned s = 0; s < NSEG; s++) begin
            for (int unsigned b = 0; b < SEG_LEN; b++) begin
                onehot_c[s*SEG_LEN + b] = seg_oh[s] & bit_oh[b];
            end
        end
    end

    assign found_c = seg_found & bit_found;
    assign index_c = found_c ? {seg_idx, bit_idx} : '0;
    assign last_c  = ((residual & ~onehot_c) == '0)
                   || ((limit_q != '0) && (ord == limit_q - CNT_W'(1)))
                   || !found_c;

    // Transaction registers and registered beat outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            residual   <= '0;
            dir_q      <= DIR_HI_FIRST;
            limit_q    <= '0;
            ord        <= '0;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            out_onehot <= '0;
            out_index  <= '0;
            out_ord    <= '0;
            out_last   <= 1'b0;
            out_none   <= 1'b0;
        end else begin
            in_ready  <= (state_nxt == IDLE);
            out_valid <= (state_nxt == EMIT);
            busy      <= (state_nxt != IDLE);
            if (abort) begin
                residual <= '0;
            end else begin
                if (accept_c) begin
                    residual <= in_vector;
                    dir_q    <= in_dir;
                    limit_q  <= in_limit;
                    ord      <= '0;
                end
                if (state == FIND) begin
                    out_onehot <= onehot_c;
                    out_index  <= index_c;
                    out_ord    <= ord;
                    out_last   <= last_c;
                    out_none   <= !found_c;
                end
                if (beat_c) begin
                    residual <= residual & ~out_onehot;
                    ord      <= ord + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_sasa_match_enum.sv
// Directed bench for sasa_match_enum (VEC_LEN = 256, SEG_LEN = 16).
module tb_sasa_match_enum;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [255:0] in_vector;
    logic         in_dir;
    logic [8:0]   in_limit;
    logic         abort;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_onehot;
    logic [7:0]   out_index;
    logic [8:0]   out_ord;
    logic         out_last;
    logic         out_none;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;

    sasa_match_enum dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_vector  (in_vector),
        .in_dir     (in_dir),
        .in_limit   (in_limit),
        .abort      (abort),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_index  (out_index),
        .out_ord    (out_ord),
        .out_last   (out_last),
        .out_none   (out_none),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer one vector; returns just after the accepting edge (block assumed idle).
    task automatic send(input logic [255:0] v, input logic d, input logic [8:0] lim);
        @(negedge clk);
        in_vector = v;
        in_dir    = d;
        in_limit  = lim;
        in_valid  = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Wait for one beat, check its payload and stability, and complete the handshake.
    task automatic get_beat(input string tag, input int exp_idx, input int exp_ord,
                            input bit exp_last, input bit exp_none, input bit rnd,
                            output int waits);
        logic [255:0] exp_oh;
        logic [255:0] oh0;
        logic [7:0]   ix0;
        logic [8:0]   od0;
        logic         l0;
        logic         n0;
        bit           seen;
        bit           stable;
        bit           done;
        int           stalls;
        exp_oh = '0;
        if (!exp_none) exp_oh[exp_idx] = 1'b1;
        seen = 0; stable = 1; done = 0; stalls = 0; waits = 0;
        oh0 = '0; ix0 = '0; od0 = '0; l0 = 1'b0; n0 = 1'b0;
        while (!done && waits < 40) begin
            @(negedge clk);
            if (out_valid) begin
                if (!seen) begin
                    seen = 1;
                    oh0 = out_onehot; ix0 = out_index; od0 = out_ord;
                    l0 = out_last; n0 = out_none;
                    check({tag, "_idx"},  256'(out_index), 256'(exp_idx));
                    check({tag, "_ord"},  256'(out_ord),   256'(exp_ord));
                    check({tag, "_last"}, 256'(out_last),  256'(exp_last));
                    check({tag, "_none"}, 256'(out_none),  256'(exp_none));
                    check({tag, "_oh"},   out_onehot,      exp_oh);
                end else if (out_onehot !== oh0 || out_index !== ix0 || out_ord !== od0 ||
                             out_last !== l0 || out_none !== n0) begin
                    stable = 0;
                end
                out_ready = (rnd && stalls < 32) ? 1'($urandom_range(0, 1)) : 1'b1;
                if (!out_ready) stalls++;
                @(posedge clk);
                if (out_ready) done = 1;
            end else begin
                waits++;
            end
        end
        if (!done) check({tag, "_timeout"}, 256'(0), 256'(1));
        else       check({tag, "_stable"}, 256'(stable), 256'(1));
    endtask

    initial begin
        logic [255:0] v3;
        int w;
        rst_n = 1'b0; in_valid = 1'b0; in_vector = '0; in_dir = 1'b0;
        in_limit = '0; abort = 1'b0; out_ready = 1'b1;
        v3 = '0; v3[200] = 1'b1; v3[17] = 1'b1; v3[3] = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 256'(in_ready), 256'(1));
        check("rst_out_valid", 256'(out_valid), 256'(0));
        check("rst_busy", 256'(busy), 256'(0));
        rst_n = 1'b1;

        // {200,17,3}, high first, unlimited.
        send(v3, 1'b0, 9'd0);
        @(negedge clk);
        check("t1_find_valid", 256'(out_valid), 256'(0));
        check("t1_find_ready", 256'(in_ready), 256'(0));
        get_beat("t1_b0", 200, 0, 0, 0, 0, w);
        check("t1_latency", 256'(w), 256'(0));
        get_beat("t1_b1", 17, 1, 0, 0, 0, w);
        get_beat("t1_b2", 3, 2, 1, 0, 0, w);
        @(negedge clk);
        check("t1_in_ready", 256'(in_ready), 256'(1));
        check("t1_busy", 256'(busy), 256'(0));

        // Same vector, low first, limit 2: bit 200 discarded.
        send(v3, 1'b1, 9'd2);
        get_beat("t2_b0", 3, 0, 0, 0, 0, w);
        get_beat("t2_b1", 17, 1, 1, 0, 0, w);
        @(negedge clk);
        check("t2_idle", 256'(in_ready), 256'(1));
        check("t2_no_beat", 256'(out_valid), 256'(0));

        // Zero vector.
        send('0, 1'b0, 9'd0);
        get_beat("t3_zero", 0, 0, 1, 1, 0, w);

        // All ones with random backpressure.
        send('1, 1'b0, 9'd0);
        for (int k = 0; k < 256; k++) begin
            get_beat($sformatf("t4_b%0d", k), 255 - k, k, k == 255, 0, 1, w);
        end
        out_ready = 1'b1;

        // Abort during the second beat wins over the handshake.
        v3 = '0; v3[255] = 1'b1; v3[0] = 1'b1;
        send(v3, 1'b0, 9'd0);
        get_beat("t5_b0", 255, 0, 0, 0, 0, w);
        @(negedge clk);
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
        check("t5_b1_valid", 256'(out_valid), 256'(1));
        check("t5_b1_idx", 256'(out_index), 256'(0));
        out_ready = 1'b1;
        abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        @(negedge clk);
        check("t5_ab_valid", 256'(out_valid), 256'(0));
        check("t5_ab_ready", 256'(in_ready), 256'(1));
        check("t5_ab_busy", 256'(busy), 256'(0));
        v3 = '0; v3[5] = 1'b1;
        send(v3, 1'b0, 9'd0);
        get_beat("t5_next", 5, 0, 1, 0, 0, w);

        // Reset while in FIND.
        v3 = '0; v3[200] = 1'b1; v3[17] = 1'b1; v3[3] = 1'b1;
        send(v3, 1'b0, 9'd0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("t6_valid", 256'(out_valid), 256'(0));
        check("t6_ready", 256'(in_ready), 256'(1));
        check("t6_busy", 256'(busy), 256'(0));
        check("t6_oh", out_onehot, '0);
        check("t6_idx", 256'(out_index), 256'(0));
        check("t6_ord", 256'(out_ord), 256'(0));
        check("t6_last", 256'(out_last), 256'(0));
        check("t6_none", 256'(out_none), 256'(0));

        // in_valid while busy is ignored.
        send(v3, 1'b0, 9'd0);
        in_vector = '0; in_vector[9] = 1'b1; in_dir = 1'b1; in_valid = 1'b1;
        get_beat("t7_b0", 200, 0, 0, 0, 0, w);
        in_valid = 1'b0;
        get_beat("t7_b1", 17, 1, 0, 0, 0, w);
        get_beat("t7_b2", 3, 2, 1, 0, 0, w);
        @(negedge clk);
        check("t7_idle", 256'(in_ready), 256'(1));
        @(negedge clk);
        check("t7_ignored", 256'(out_valid), 256'(0));
        check("t7_not_busy", 256'(busy), 256'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
